// File: rtl/gaus_rng_clt.sv
// Approximate Gaussian random number generator using the central limit theorem.
// A 32-bit Galois LFSR supplies uniform samples; NSUM of them are summed,
// scaled back to OUT_W bits and re-centred on zero. The result is presented
// on a valid/ready output port.
module gaus_rng_clt #(
  parameter int unsigned OUT_W        = 16,           // 2..32
  parameter int unsigned NSUM         = 4,            // power of two, 1..256
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1_ACE1 // must be non-zero
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             en,
  input  logic             load_seed,
  input  logic [31:0]      seed,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] rnd_out
);

  localparam int unsigned LOG2N = $clog2(NSUM);
  // Sum of NSUM values of OUT_W bits needs LOG2N extra bits, so it cannot overflow.
  localparam int unsigned ACC_W = OUT_W + LOG2N;
  localparam int unsigned CNT_W = (LOG2N > 0) ? LOG2N : 1;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(NSUM - 1);
  // Taps for x^32 + x^22 + x^2 + x + 1 in right-shift Galois form.
  localparam logic [31:0]      Poly    = 32'h8020_0003;
  // Inverting the MSB of an unsigned mean is the same as subtracting half range.
  localparam logic [OUT_W-1:0] MsbFlip = {1'b1, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StValid
  } state_e;

  state_e             state_q;
  logic [31:0]        lfsr_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [31:0]        lfsr_step;
  logic [31:0]        seed_eff;
  logic [OUT_W-1:0]   uni;
  logic [ACC_W-1:0]   sum;
  logic [OUT_W-1:0]   mean;

  // Next LFSR state, current uniform sample, running sum and its scaled mean.
  always_comb begin
    lfsr_step = {1'b0, lfsr_q[31:1]};
    if (lfsr_q[0]) begin
      lfsr_step = lfsr_step ^ Poly;
    end
    uni      = lfsr_q[31 -: OUT_W];
    sum      = acc_q + ACC_W'(uni);
    mean     = sum[LOG2N +: OUT_W];
    // A zero seed would lock the LFSR at zero forever.
    seed_eff = (seed == 32'd0) ? SEED_DEFAULT : seed;
  end

  // Control FSM with registered outputs; seed load overrides every state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      lfsr_q    <= SEED_DEFAULT;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      rnd_out   <= '0;
    end else if (load_seed) begin
      // Any sample in flight, even one being handed off this edge, is dropped.
      state_q   <= StIdle;
      lfsr_q    <= seed_eff;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          acc_q     <= '0;
          cnt_q     <= '0;
          out_valid <= 1'b0;
          if (en) begin
            state_q <= StAccum;
          end
        end
        StAccum: begin
          if (en) begin
            lfsr_q <= lfsr_step;
            if (cnt_q == CntLast) begin
              state_q   <= StValid;
              out_valid <= 1'b1;
              rnd_out   <= mean ^ MsbFlip;
              acc_q     <= '0;
              cnt_q     <= '0;
            end else begin
              acc_q <= sum;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        StValid: begin
          // LFSR and output hold here until the consumer takes the sample.
          if (out_ready) begin
            state_q   <= StAccum;
            out_valid <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
          end
        end
        default: begin
          state_q   <= StIdle;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gaus_rng_clt.sv
// Bench for gaus_rng_clt: two instances (NSUM=4 and NSUM=1, both 8-bit) share
// one stimulus stream and are checked every cycle against a sample-level model.
module tb_gaus_rng_clt;

  localparam logic [31:0] SeedDef = 32'hACE1_ACE1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        en = 1'b0;
  logic        load_seed = 1'b0;
  logic [31:0] seed = 32'd0;
  logic        out_ready = 1'b0;
  logic [1:0]  ov;
  logic [7:0]  ro0;
  logic [7:0]  ro1;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  always #5 Clk = ~Clk;

  gaus_rng_clt #(.OUT_W(8), .NSUM(4), .SEED_DEFAULT(SeedDef)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .en(en), .load_seed(load_seed), .seed(seed),
    .out_ready(out_ready), .out_valid(ov[0]), .rnd_out(ro0)
  );

  gaus_rng_clt #(.OUT_W(8), .NSUM(1), .SEED_DEFAULT(SeedDef)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .en(en), .load_seed(load_seed), .seed(seed),
    .out_ready(out_ready), .out_valid(ov[1]), .rnd_out(ro1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] nxt(input logic [31:0] s);
    logic [31:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 32'h8020_0003;
    return t;
  endfunction

  function automatic logic [31:0] advance(input logic [31:0] base, input int n);
    logic [31:0] s;
    s = base;
    for (int j = 0; j < n; j++) s = nxt(s);
    return s;
  endfunction

  // Mean of n uniforms (top 8 bits of successive states) minus 128, as 8 bits.
  function automatic logic [7:0] sample_from(input logic [31:0] base, input int n);
    logic [31:0] s;
    int sum;
    s = base;
    sum = 0;
    for (int j = 0; j < n; j++) begin
      sum += int'(s[31:24]);
      s = nxt(s);
    end
    return 8'((sum / n) - 128);
  endfunction

  int          ns     [2] = '{4, 1};
  logic [31:0] m_base [2];
  bit          m_idle [2];
  bit          m_valid[2];
  int          m_need [2];
  logic [7:0]  m_exp  [2];

  always @(posedge Clk or negedge Reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!Reset) begin
        m_base[i]  = SeedDef;
        m_idle[i]  = 1'b1;
        m_valid[i] = 1'b0;
        m_need[i]  = ns[i];
      end else if (load_seed) begin
        m_base[i]  = (seed == 32'd0) ? SeedDef : seed;
        m_idle[i]  = 1'b1;
        m_valid[i] = 1'b0;
      end else if (m_idle[i]) begin
        if (en) begin
          m_idle[i] = 1'b0;
          m_need[i] = ns[i];
        end
      end else if (m_valid[i]) begin
        if (out_ready) begin
          m_valid[i] = 1'b0;
          m_need[i]  = ns[i];
          m_base[i]  = advance(m_base[i], ns[i]);
        end
      end else if (en) begin
        m_need[i]--;
        if (m_need[i] == 0) m_valid[i] = 1'b1;
      end
      m_exp[i] = sample_from(m_base[i], ns[i]);
    end
  end

  // Per-cycle comparison against the model.
  logic [7:0] r_cmp;
  always @(negedge Clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        r_cmp = (i == 0) ? ro0 : ro1;
        check($sformatf("valid_n%0d", ns[i]), 32'(ov[i]), 32'(m_valid[i]));
        if (m_valid[i]) check($sformatf("data_n%0d", ns[i]), 32'(r_cmp), 32'(m_exp[i]));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_valid0(input string nm);
    int k;
    k = 0;
    while (!ov[0] && k < 50) begin
      tick();
      k++;
    end
    total++;
    if (!ov[0]) begin
      bad++;
      $display("FAIL %s: out_valid still 0 after %0d cycles, want 1", nm, k);
    end
  endtask

  logic [7:0] w;

  initial begin
    // Model pins: hand-derived values for seed 1.
    check("pin_n4", 32'(sample_from(32'd1, 4)), 32'h E8);
    check("pin_n1_0", 32'(sample_from(32'd1, 1)), 32'h80);
    check("pin_n1_1", 32'(sample_from(advance(32'd1, 1), 1)), 32'h00);
    check("pin_n1_2", 32'(sample_from(advance(32'd1, 2), 1)), 32'h40);

    repeat (3) tick();
    check("rst_valid", 32'(ov), 32'd0);
    check("rst_out4", 32'(ro0), 32'd0);
    check("rst_out1", 32'(ro1), 32'd0);
    Reset = 1'b1;
    chk_on = 1'b1;

    // Seed 1, continuous enable and ready.
    load_seed = 1'b1;
    seed = 32'd1;
    en = 1'b1;
    out_ready = 1'b1;
    tick();
    load_seed = 1'b0;
    @(negedge Clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (c == 1 || c == 3 || c == 5) check($sformatf("seq1_idle_c%0d", c), 32'(ov[1]), 32'd0);
      if (c == 2 || c == 4 || c == 6) begin
        w = (c == 2) ? 8'h80 : (c == 4) ? 8'h00 : 8'h40;
        check($sformatf("seq1_valid_c%0d", c), 32'(ov[1]), 32'd1);
        check($sformatf("seq1_data_c%0d", c), 32'(ro1), 32'(w));
      end
      if (c == 4) check("n4_not_yet", 32'(ov[0]), 32'd0);
      if (c == 5) begin
        check("n4_latency", 32'(ov[0]), 32'd1);
        check("n4_first", 32'(ro0), 32'hE8);
      end
      if (c == 6) check("n4_taken", 32'(ov[0]), 32'd0);
    end

    // Zero seed falls back to the default seed.
    tick();
    load_seed = 1'b1;
    seed = 32'd0;
    tick();
    load_seed = 1'b0;
    repeat (30) tick();

    // Stall in VALID with en toggling, then accept on first ready edge.
    out_ready = 1'b0;
    wait_valid0("stall_wait");
    for (int k = 0; k < 10; k++) begin
      tick();
      en = ~en;
    end
    check("stall_hold", 32'(ov[0]), 32'd1);
    out_ready = 1'b1;
    tick();
    check("stall_accept", 32'(ov[0]), 32'd0);

    // Enable pulsed during accumulation.
    for (int k = 0; k < 16; k++) begin
      en = k[0];
      tick();
    end
    en = 1'b1;

    // Asynchronous reset mid-accumulation.
    wait_valid0("pre_rst_wait");
    tick();
    tick();
    #2 Reset = 1'b0;
    #1;
    check("rst_mid_valid", 32'(ov), 32'd0);
    check("rst_mid_out", 32'(ro0), 32'd0);
    tick();
    Reset = 1'b1;

    // Seed load while VALID.
    out_ready = 1'b0;
    wait_valid0("load_wait");
    load_seed = 1'b1;
    seed = 32'h1234_5679;
    tick();
    load_seed = 1'b0;
    check("load_in_valid", 32'(ov[0]), 32'd0);
    out_ready = 1'b1;
    wait_valid0("load_restart");

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      en        = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      load_seed = ($urandom_range(0, 49) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 Reset = 1'b0;
        #4 Reset = 1'b1;
      end
    end

    tick();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gaus_rng_clt.md
GAUS_RNG_CLT -- requirements
Module: gaus_rng_clt

Interface
REQ-001 Parameter OUT_W, default 16, output sample width in bits; legal range 2..32.
REQ-002 Parameter NSUM, default 4, number of uniform samples averaged per output; power of two, 1..256.
REQ-003 Parameter SEED_DEFAULT, default 32'hACE1_ACE1, non-zero LFSR state used on reset and on zero-seed load.
REQ-004 Clk  input  1  clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  advance enable; when low, LFSR and accumulator hold.
REQ-007 load_seed  input  1  single-cycle seed load request.
REQ-008 seed  input  32  seed value, sampled when load_seed=1.
REQ-009 out_ready  input  1  consumer accepts the current output.
REQ-010 out_valid  output  1  rnd_out holds a complete sample.
REQ-011 rnd_out  output  OUT_W  signed two's-complement approx-Gaussian sample, centred on zero.

Function
REQ-012 LFSR SHALL be 32-bit right-shift Galois, polynomial x^32+x^22+x^2+x+1: if s[0]=1 then next = (s>>1) ^ 32'h8020_0003, else next = s>>1.
REQ-013 Uniform sample u SHALL be lfsr[31:32-OUT_W] of the current state, taken in the same cycle the LFSR advances.
REQ-014 FSM states SHALL be IDLE, ACCUM, VALID.
REQ-015 IDLE: acc=0, cnt=0, out_valid=0; moves to ACCUM on the next edge when en=1.
REQ-016 ACCUM with en=1: acc += u, LFSR advances, cnt++; on the edge where cnt==NSUM-1, go to VALID and register rnd_out.
REQ-017 ACCUM with en=0: acc, cnt and LFSR hold; state stays ACCUM.
REQ-018 Accumulator width SHALL be OUT_W+log2(NSUM); no overflow possible.
REQ-019 rnd_out SHALL be the final sum (including the last u) >> log2(NSUM), with the MSB inverted, i.e. mean minus 2^(OUT_W-1).
REQ-020 VALID: out_valid=1; rnd_out and LFSR held stable regardless of en until handshake.
REQ-021 Handshake: out_valid & out_ready on an edge completes the transfer; the next state is ACCUM with acc=0 and cnt=0, and out_valid=0 the following cycle.
REQ-022 Latency: exactly NSUM en-high cycles in ACCUM from ACCUM entry to out_valid=1; steady-state throughput is one sample per NSUM+1 cycles with out_ready held high.
REQ-023 load_seed=1 SHALL take priority over all other activity in every state: LFSR <= seed (SEED_DEFAULT if seed==0), acc=0, cnt=0, state <= IDLE, out_valid=0 next cycle.
REQ-024 An in-flight sample SHALL be discarded when load_seed coincides with a handshake; the transfer is still counted by the consumer.
REQ-025 LFSR SHALL never hold all-zero.

Reset
REQ-026 Reset low SHALL asynchronously force state=IDLE, LFSR=SEED_DEFAULT, acc=0, cnt=0, out_valid=0, rnd_out=0.
REQ-027 Reset deassertion mid-accumulation SHALL restart from IDLE; no partial sample is ever presented.

Verification
REQ-028 OUT_W=8, NSUM=1, load_seed with seed=1, en=1, out_ready=1 -> rnd_out sequence 8'h80, 8'h00, 8'h40 (LFSR states 0000_0001, 8020_0003, C030_0002).
REQ-029 OUT_W=8, NSUM=4, seed=1, en=1 -> first rnd_out=8'hE8 (samples 00, 80, C0, 60; sum 0x1A0; >>2 = 0x68; MSB inverted), asserted 4 cycles after ACCUM entry.
REQ-030 load_seed with seed=0 -> LFSR=SEED_DEFAULT; output matches a run seeded with SEED_DEFAULT directly.
REQ-031 out_ready=0 for 10 cycles while VALID -> rnd_out and out_valid stable; toggling en has no effect; accepted on the first ready edge.
REQ-032 en pulsed 1-0-1-0 during ACCUM -> output identical to a continuous-en run; latency stretched by the en-low cycles.
REQ-033 Reset asserted mid-ACCUM, and load_seed asserted in VALID -> out_valid=0 immediately (reset) or next cycle (load), followed by a clean restart from IDLE.
